hazard_stall_controller: RTL and testbench
==========================================

Name: hazard_stall_controller

Overview:
Pipeline sequencing controller for the 5-stage RISC-V core. It produces per-stage register enables and flushes for three cases: load-use stall, taken-branch flush, and data-memory wait freeze. It owns a memory-wait FSM with a timeout fault, plus saturating hazard event counters. It sits beside the forwarding logic and drives PC, IF/ID, ID/EX, EX/MEM and MEM/WB control.

Parameters:
MEM_TIMEOUT, 16, consecutive not-ready dmem cycles before fault (>=1)
CNT_W, 16, width of each event counter
TO_W, 8, width of wait counter (2^TO_W > MEM_TIMEOUT)

Ports:
clk  in  1  core clock, rising edge
reset  in  1  asynchronous, active-high reset
IF_ID_rs1  in  5  rs1 of instruction in ID
IF_ID_rs2  in  5  rs2 of instruction in ID
IF_ID_useRs1  in  1  ID instruction reads rs1
IF_ID_useRs2  in  1  ID instruction reads rs2
ID_EX_rd  in  5  rd of instruction in EX
ID_EX_memRead  in  1  EX instruction is a load
branch_taken  in  1  EX resolved taken branch/jump
dmem_req  in  1  MEM stage has load/store outstanding
dmem_ready  in  1  data memory completes access this cycle
cnt_clr  in  1  synchronous clear of event counters
pc_en  out  1  PC register write enable
if_id_en  out  1  IF/ID write enable
id_ex_en  out  1  ID/EX write enable
ex_mem_en  out  1  EX/MEM write enable
if_id_flush  out  1  IF/ID loads NOP
id_ex_flush  out  1  ID/EX loads bubble
mem_wb_bubble  out  1  MEM/WB loads bubble (regWrite=0)
mem_err  out  1  memory timeout fault, sticky
lu_cnt  out  CNT_W  load-use stall cycles
br_cnt  out  CNT_W  branch flush cycles
mw_cnt  out  CNT_W  memory freeze cycles

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- Reset: state=RUN, wait_cnt=0, lu/br/mw_cnt=0, mem_err=0. While reset=1, all enables, flushes and mem_wb_bubble are 0.
- States: RUN, WAIT, FAULT (shared encoding). Control outputs are combinational from state and inputs; zero-cycle latency.
- freeze = (state!=FAULT) & dmem_req & ~dmem_ready.
- lu = ID_EX_memRead & ID_EX_rd!=0 & ((useRs1 & rd==rs1) | (useRs2 & rd==rs2)).
- Priority per cycle: FAULT > freeze > branch_taken > lu > normal.
- FAULT: all four enables 0, flushes 0, mem_wb_bubble=1, mem_err=1. Exit only via reset.
- freeze:
  - pc/if_id/id_ex/ex_mem_en=0; flushes 0; mem_wb_bubble=1.
  - Branch and load-use are ignored that cycle; stages hold, so both re-evaluate after the freeze.
- branch_taken:
  - All enables 1, if_id_flush=1, id_ex_flush=1, mem_wb_bubble=0.
  - Two bubbles; the PC takes the target.
  - A simultaneous lu is ignored because its instruction is flushed.
- lu:
  - pc_en=0, if_id_en=0, id_ex_en=1, id_ex_flush=1, ex_mem_en=1.
  - Exactly one bubble; the next cycle the load is in MEM and forwarding resolves the dependency.
- normal: all enables 1, flushes 0, mem_wb_bubble=0.
- FSM transitions, evaluated at clk edge:
  - RUN/WAIT with freeze: if wait_cnt==MEM_TIMEOUT-1, go to FAULT. Otherwise go to WAIT with wait_cnt+1.
  - RUN/WAIT without freeze: go to RUN with wait_cnt=0. A ready in WAIT releases the freeze the same cycle.
  - MEM_TIMEOUT=1 means the first not-ready cycle faults.
- Counters:
  - Each counter increments by 1 per cycle its case is the applied action: lu→lu_cnt, branch→br_cnt, freeze→mw_cnt.
  - Counters saturate at all-ones. They hold in FAULT.
  - cnt_clr zeroes all three and wins over a same-cycle increment.
- Reset mid-WAIT returns to RUN immediately, asynchronously.

Decomposition:
- Shared package: state encoding localparams (RUN/WAIT/FAULT), register-index width 5, NOP/bubble control constants.
- One sub-module, hazard_event_counter: a saturating counter with inc and clr inputs, CNT_W parameter, instantiated three times.

Test Plan:
- Load-use: ID_EX_memRead=1, rd=5, rs1=5, useRs1=1 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1; lu_cnt=1. With rd=0, no stall.
- Branch with simultaneous lu: branch_taken=1 and lu=1 -> all enables 1, if_id_flush=id_ex_flush=1; br_cnt=1, lu_cnt=0.
- Memory wait: dmem_req=1, ready=0 for 3 cycles, then ready=1 -> 3 freeze cycles with enables 0 and mem_wb_bubble=1. Release in the ready cycle; mw_cnt=3, state RUN.
- Timeout: MEM_TIMEOUT=4, dmem_req=1, ready held 0 -> after the 4th edge, mem_err=1 sticky and enables 0 even when ready rises. Reset clears.
- Freeze with branch: freeze and branch_taken together -> no flushes during freeze. After ready, the flush occurs with br_cnt=1.
- Counters: CNT_W=4, 20 load-use cycles -> lu_cnt saturates at 15. cnt_clr together with an lu cycle -> lu_cnt=0.

Source files
------------

// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Holds the FSM state encoding, register-index width and per-action control words.
package hazard_stall_controller_pkg;

   localparam int unsigned REG_IDX_W = 5;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_WAIT  = 2'd1,
      ST_FAULT = 2'd2
   } state_t;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic id_ex_en;
      logic ex_mem_en;
      logic if_id_flush;
      logic id_ex_flush;
      logic mem_wb_bubble;
   } ctrl_t;

   localparam ctrl_t CTRL_OFF    = '0;
   localparam ctrl_t CTRL_NORMAL = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam ctrl_t CTRL_HOLD   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
   localparam ctrl_t CTRL_LU     = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

   // Source register hit against the EX-stage destination.
   function automatic logic reg_hit(input logic use_rs,
                                    input logic [REG_IDX_W-1:0] rs,
                                    input logic [REG_IDX_W-1:0] rd);
      return use_rs && (rs == rd);
   endfunction

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Hazard inputs from the pipeline and per-stage enable/flush controls back to it.
interface hazard_stall_controller_if;
   import hazard_stall_controller_pkg::*;

   logic [REG_IDX_W-1:0] IF_ID_rs1;
   logic [REG_IDX_W-1:0] IF_ID_rs2;
   logic                 IF_ID_useRs1;
   logic                 IF_ID_useRs2;
   logic [REG_IDX_W-1:0] ID_EX_rd;
   logic                 ID_EX_memRead;
   logic                 branch_taken;
   logic                 dmem_req;
   logic                 dmem_ready;

   logic pc_en;
   logic if_id_en;
   logic id_ex_en;
   logic ex_mem_en;
   logic if_id_flush;
   logic id_ex_flush;
   logic mem_wb_bubble;

   modport master (
      output IF_ID_rs1, IF_ID_rs2, IF_ID_useRs1, IF_ID_useRs2,
      output ID_EX_rd, ID_EX_memRead, branch_taken, dmem_req, dmem_ready,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en,
      input  if_id_flush, id_ex_flush, mem_wb_bubble
   );

   modport slave (
      input  IF_ID_rs1, IF_ID_rs2, IF_ID_useRs1, IF_ID_useRs2,
      input  ID_EX_rd, ID_EX_memRead, branch_taken, dmem_req, dmem_ready,
      output pc_en, if_id_en, id_ex_en, ex_mem_en,
      output if_id_flush, id_ex_flush, mem_wb_bubble
   );

endinterface

// File: rtl/hazard_stall_controller_event_counter.sv
// Saturating event counter; a clear wins over a same-cycle increment.
module hazard_event_counter #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         count <= '0;
      else if (clr)
         count <= '0;
      else if (inc && (count != '1))
         count <= count + 1'b1;
   end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing: load-use stall, taken-branch flush and dmem-wait freeze,
// with a memory-wait timeout FSM and saturating hazard event counters.
module hazard_stall_controller
   import hazard_stall_controller_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned TO_W        = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   hazard_stall_controller_if.slave  hz,
   input  logic                      cnt_clr,
   output logic                      mem_err,
   output logic [CNT_W-1:0]          lu_cnt,
   output logic [CNT_W-1:0]          br_cnt,
   output logic [CNT_W-1:0]          mw_cnt
);

   state_t          state_q, state_d;
   logic [TO_W-1:0] wait_q, wait_d;
   ctrl_t           ctrl;
   logic            freeze, lu;
   logic            act_lu, act_br, act_mw;

   assign freeze = (state_q != ST_FAULT) && hz.dmem_req && !hz.dmem_ready;
   assign lu     = hz.ID_EX_memRead && (hz.ID_EX_rd != '0) &&
                   (reg_hit(hz.IF_ID_useRs1, hz.IF_ID_rs1, hz.ID_EX_rd) ||
                    reg_hit(hz.IF_ID_useRs2, hz.IF_ID_rs2, hz.ID_EX_rd));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_RUN;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   always_comb begin
      state_d = state_q;
      wait_d  = wait_q;
      ctrl    = CTRL_NORMAL;
      act_lu  = 1'b0;
      act_br  = 1'b0;
      act_mw  = 1'b0;

      if (state_q != ST_FAULT) begin
         if (freeze) begin
            if (wait_q == TO_W'(MEM_TIMEOUT - 1)) begin
               state_d = ST_FAULT;
            end else begin
               state_d = ST_WAIT;
               wait_d  = wait_q + 1'b1;
            end
         end else begin
            state_d = ST_RUN;
            wait_d  = '0;
         end
      end

      // Action priority: fault, freeze, branch, load-use; reset forces all off.
      if (reset) begin
         ctrl = CTRL_OFF;
      end else if (state_q == ST_FAULT) begin
         ctrl = CTRL_HOLD;
      end else if (freeze) begin
         ctrl   = CTRL_HOLD;
         act_mw = 1'b1;
      end else if (hz.branch_taken) begin
         ctrl   = CTRL_BRANCH;
         act_br = 1'b1;
      end else if (lu) begin
         ctrl   = CTRL_LU;
         act_lu = 1'b1;
      end
   end

   assign hz.pc_en         = ctrl.pc_en;
   assign hz.if_id_en      = ctrl.if_id_en;
   assign hz.id_ex_en      = ctrl.id_ex_en;
   assign hz.ex_mem_en     = ctrl.ex_mem_en;
   assign hz.if_id_flush   = ctrl.if_id_flush;
   assign hz.id_ex_flush   = ctrl.id_ex_flush;
   assign hz.mem_wb_bubble = ctrl.mem_wb_bubble;
   assign mem_err          = (state_q == ST_FAULT);

   hazard_event_counter #(.CNT_W(CNT_W)) u_lu_cnt (
      .clk(clk), .reset(reset), .inc(act_lu), .clr(cnt_clr), .count(lu_cnt)
   );

   hazard_event_counter #(.CNT_W(CNT_W)) u_br_cnt (
      .clk(clk), .reset(reset), .inc(act_br), .clr(cnt_clr), .count(br_cnt)
   );

   hazard_event_counter #(.CNT_W(CNT_W)) u_mw_cnt (
      .clk(clk), .reset(reset), .inc(act_mw), .clr(cnt_clr), .count(mw_cnt)
   );

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench: main DUT with MEM_TIMEOUT=4/CNT_W=4, second DUT with MEM_TIMEOUT=1.
module tb_hazard_stall_controller;

   // Control word order: pc, if_id, id_ex, ex_mem enables, if_id_flush, id_ex_flush, mem_wb_bubble
   localparam logic [6:0] C_OFF    = 7'b0000_000;
   localparam logic [6:0] C_NORMAL = 7'b1111_000;
   localparam logic [6:0] C_HOLD   = 7'b0000_001;
   localparam logic [6:0] C_BRANCH = 7'b1111_110;
   localparam logic [6:0] C_LU     = 7'b0011_010;

   logic clk = 1'b0;
   logic reset;
   logic cnt_clr;

   logic       mem_err, mem_err2;
   logic [3:0] lu_cnt, br_cnt, mw_cnt;
   logic [15:0] lu_cnt2, br_cnt2, mw_cnt2;
   logic [6:0] ctl, ctl2;

   int vec_cnt = 0;
   int err_cnt = 0;

   hazard_stall_controller_if hz ();
   hazard_stall_controller_if hz2 ();

   hazard_stall_controller #(.MEM_TIMEOUT(4), .CNT_W(4), .TO_W(8)) dut (
      .clk(clk), .reset(reset), .hz(hz.slave), .cnt_clr(cnt_clr),
      .mem_err(mem_err), .lu_cnt(lu_cnt), .br_cnt(br_cnt), .mw_cnt(mw_cnt)
   );

   hazard_stall_controller #(.MEM_TIMEOUT(1), .CNT_W(16), .TO_W(8)) dut2 (
      .clk(clk), .reset(reset), .hz(hz2.slave), .cnt_clr(cnt_clr),
      .mem_err(mem_err2), .lu_cnt(lu_cnt2), .br_cnt(br_cnt2), .mw_cnt(mw_cnt2)
   );

   assign ctl  = {hz.pc_en, hz.if_id_en, hz.id_ex_en, hz.ex_mem_en,
                  hz.if_id_flush, hz.id_ex_flush, hz.mem_wb_bubble};
   assign ctl2 = {hz2.pc_en, hz2.if_id_en, hz2.id_ex_en, hz2.ex_mem_en,
                  hz2.if_id_flush, hz2.id_ex_flush, hz2.mem_wb_bubble};

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      hz.IF_ID_rs1 = '0;  hz.IF_ID_rs2 = '0;
      hz.IF_ID_useRs1 = 1'b0;  hz.IF_ID_useRs2 = 1'b0;
      hz.ID_EX_rd = '0;  hz.ID_EX_memRead = 1'b0;
      hz.branch_taken = 1'b0;  hz.dmem_req = 1'b0;  hz.dmem_ready = 1'b0;
   endtask

   task automatic idle2();
      hz2.IF_ID_rs1 = '0;  hz2.IF_ID_rs2 = '0;
      hz2.IF_ID_useRs1 = 1'b0;  hz2.IF_ID_useRs2 = 1'b0;
      hz2.ID_EX_rd = '0;  hz2.ID_EX_memRead = 1'b0;
      hz2.branch_taken = 1'b0;  hz2.dmem_req = 1'b0;  hz2.dmem_ready = 1'b0;
   endtask

   task automatic drive_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic use1, input logic use2, input logic mrd);
      hz.ID_EX_memRead = mrd;  hz.ID_EX_rd = rd;
      hz.IF_ID_rs1 = rs1;  hz.IF_ID_rs2 = rs2;
      hz.IF_ID_useRs1 = use1;  hz.IF_ID_useRs2 = use2;
   endtask

   task automatic pulse_reset();
      tick();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      idle();
      idle2();
      cnt_clr = 1'b0;
   endtask

   task automatic clear_counters();
      idle();
      cnt_clr = 1'b1;
      tick();
      cnt_clr = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cnt_clr = 1'b0;
      idle(); idle2();
      hz.branch_taken = 1'b1;
      hz.dmem_req = 1'b1;
      hz2.branch_taken = 1'b1;
      #2;
      vec_cnt++;
      if (ctl !== C_OFF) begin err_cnt++; $display("FAIL reset_ctl: got %b exp %b", ctl, C_OFF); end
      vec_cnt++;
      if (ctl2 !== C_OFF) begin err_cnt++; $display("FAIL reset_ctl2: got %b exp %b", ctl2, C_OFF); end
      vec_cnt++;
      if ({mem_err, lu_cnt, br_cnt, mw_cnt} !== 13'd0) begin
         err_cnt++; $display("FAIL reset_state: got err=%b lu=%0d br=%0d mw=%0d exp all 0", mem_err, lu_cnt, br_cnt, mw_cnt);
      end
      tick();
      #2;
      reset = 1'b0;
      idle(); idle2();
      #1;
      vec_cnt++;
      if (ctl !== C_NORMAL) begin err_cnt++; $display("FAIL post_reset_normal: got %b exp %b", ctl, C_NORMAL); end
   endtask

   task automatic test_load_use();
      clear_counters();
      drive_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
      #1;
      vec_cnt++;
      if (ctl !== C_LU) begin err_cnt++; $display("FAIL lu_rs1_ctl: got %b exp %b", ctl, C_LU); end
      tick();
      idle();
      #1;
      vec_cnt++;
      if (lu_cnt !== 4'd1) begin err_cnt++; $display("FAIL lu_cnt_one: got %0d exp 1", lu_cnt); end
      vec_cnt++;
      if (ctl !== C_NORMAL) begin err_cnt++; $display("FAIL lu_release: got %b exp %b", ctl, C_NORMAL); end
      drive_lu(5'd0, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1);
      #1;
      vec_cnt++;
      if (ctl !== C_NORMAL) begin err_cnt++; $display("FAIL lu_rd_zero: got %b exp %b", ctl, C_NORMAL); end
      tick();
      drive_lu(5'd7, 5'd3, 5'd7, 1'b1, 1'b1, 1'b1);
      #1;
      vec_cnt++;
      if (ctl !== C_LU) begin err_cnt++; $display("FAIL lu_rs2_ctl: got %b exp %b", ctl, C_LU); end
      tick();
      drive_lu(5'd7, 5'd3, 5'd7, 1'b1, 1'b0, 1'b1);
      #1;
      vec_cnt++;
      if (ctl !== C_NORMAL) begin err_cnt++; $display("FAIL lu_rs2_unused: got %b exp %b", ctl, C_NORMAL); end
      tick();
      drive_lu(5'd7, 5'd7, 5'd7, 1'b1, 1'b1, 1'b0);
      #1;
      vec_cnt++;
      if (ctl !== C_NORMAL) begin err_cnt++; $display("FAIL lu_not_load: got %b exp %b", ctl, C_NORMAL); end
      tick();
      idle();
      #1;
      vec_cnt++;
      if (lu_cnt !== 4'd2) begin err_cnt++; $display("FAIL lu_cnt_two: got %0d exp 2", lu_cnt); end
   endtask

   task automatic test_branch_with_lu();
      clear_counters();
      drive_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
      hz.branch_taken = 1'b1;
      #1;
      vec_cnt++;
      if (ctl !== C_BRANCH) begin err_cnt++; $display("FAIL br_lu_ctl: got %b exp %b", ctl, C_BRANCH); end
      tick();
      idle();
      #1;
      vec_cnt++;
      if ({br_cnt, lu_cnt} !== {4'd1, 4'd0}) begin
         err_cnt++; $display("FAIL br_lu_cnt: got br=%0d lu=%0d exp br=1 lu=0", br_cnt, lu_cnt);
      end
   endtask

   task automatic test_mem_wait();
      clear_counters();
      hz.dmem_req = 1'b1;
      hz.dmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (i == 1) drive_lu(5'd5, 5'd5, 5'd0, 1'b1, 1'b0, 1'b1);
         #1;
         vec_cnt++;
         if (ctl !== C_HOLD) begin err_cnt++; $display("FAIL mw_freeze_%0d: got %b exp %b", i, ctl, C_HOLD); end
         tick();
         idle();
         hz.dmem_req = 1'b1;
      end
      hz.dmem_ready = 1'b1;
      #1;
      vec_cnt++;
      if (ctl !== C_NORMAL) begin err_cnt++; $display("FAIL mw_release: got %b exp %b", ctl, C_NORMAL); end
      tick();
      idle();
      #1;
      vec_cnt++;
      if ({mw_cnt, lu_cnt, mem_err} !== {4'd3, 4'd0, 1'b0}) begin
         err_cnt++; $display("FAIL mw_cnt: got mw=%0d lu=%0d err=%b exp mw=3 lu=0 err=0", mw_cnt, lu_cnt, mem_err);
      end
      // Wait count must have restarted: three more not-ready cycles stay below the timeout of 4.
      hz.dmem_req = 1'b1;
      repeat (3) tick();
      hz.dmem_ready = 1'b1;
      #1;
      vec_cnt++;
      if ({mem_err, ctl} !== {1'b0, C_NORMAL}) begin
         err_cnt++; $display("FAIL mw_wait_restart: got err=%b ctl=%b exp err=0 ctl=%b", mem_err, ctl, C_NORMAL);
      end
      tick();
      idle();
   endtask

   task automatic test_timeout();
      pulse_reset();
      hz.dmem_req = 1'b1;
      hz.dmem_ready = 1'b0;
      repeat (3) tick();
      #1;
      vec_cnt++;
      if ({mem_err, ctl} !== {1'b0, C_HOLD}) begin
         err_cnt++; $display("FAIL to_before_edge4: got err=%b ctl=%b exp err=0 ctl=%b", mem_err, ctl, C_HOLD);
      end
      tick();
      vec_cnt++;
      if (mem_err !== 1'b1) begin err_cnt++; $display("FAIL to_after_edge4: got err=%b exp 1", mem_err); end
      hz.dmem_ready = 1'b1;
      hz.branch_taken = 1'b1;
      #1;
      vec_cnt++;
      if ({mem_err, ctl} !== {1'b1, C_HOLD}) begin
         err_cnt++; $display("FAIL to_sticky: got err=%b ctl=%b exp err=1 ctl=%b", mem_err, ctl, C_HOLD);
      end
      repeat (2) tick();
      vec_cnt++;
      if ({mem_err, mw_cnt, br_cnt} !== {1'b1, 4'd4, 4'd0}) begin
         err_cnt++; $display("FAIL to_cnt_hold: got err=%b mw=%0d br=%0d exp err=1 mw=4 br=0", mem_err, mw_cnt, br_cnt);
      end
      pulse_reset();
      #1;
      vec_cnt++;
      if ({mem_err, mw_cnt, ctl} !== {1'b0, 4'd0, C_NORMAL}) begin
         err_cnt++; $display("FAIL to_reset_clear: got err=%b mw=%0d ctl=%b exp err=0 mw=0 ctl=%b", mem_err, mw_cnt, ctl, C_NORMAL);
      end
   endtask

   task automatic test_reset_mid_wait();
      pulse_reset();
      hz.dmem_req = 1'b1;
      hz.dmem_ready = 1'b0;
      repeat (3) tick();
      #2;
      reset = 1'b1;
      #1;
      vec_cnt++;
      if ({mem_err, ctl, mw_cnt} !== {1'b0, C_OFF, 4'd0}) begin
         err_cnt++; $display("FAIL rst_mid_wait: got err=%b ctl=%b mw=%0d exp err=0 ctl=%b mw=0", mem_err, ctl, mw_cnt, C_OFF);
      end
      #1;
      reset = 1'b0;
      repeat (3) tick();
      #1;
      vec_cnt++;
      if ({mem_err, ctl} !== {1'b0, C_HOLD}) begin
         err_cnt++; $display("FAIL rst_wait_restart: got err=%b ctl=%b exp err=0 ctl=%b", mem_err, ctl, C_HOLD);
      end
      hz.dmem_ready = 1'b1;
      tick();
      idle();
   endtask

   task automatic test_freeze_with_branch();
      clear_counters();
      hz.dmem_req = 1'b1;
      hz.dmem_ready = 1'b0;
      hz.branch_taken = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         vec_cnt++;
         if (ctl !== C_HOLD) begin err_cnt++; $display("FAIL fb_freeze_%0d: got %b exp %b", i, ctl, C_HOLD); end
         tick();
      end
      hz.dmem_ready = 1'b1;
      #1;
      vec_cnt++;
      if (ctl !== C_BRANCH) begin err_cnt++; $display("FAIL fb_flush: got %b exp %b", ctl, C_BRANCH); end
      tick();
      idle();
      #1;
      vec_cnt++;
      if ({br_cnt, mw_cnt} !== {4'd1, 4'd2}) begin
         err_cnt++; $display("FAIL fb_cnt: got br=%0d mw=%0d exp br=1 mw=2", br_cnt, mw_cnt);
      end
   endtask

   task automatic test_saturation();
      clear_counters();
      drive_lu(5'd9, 5'd1, 5'd9, 1'b0, 1'b1, 1'b1);
      repeat (15) tick();
      vec_cnt++;
      if (lu_cnt !== 4'd15) begin err_cnt++; $display("FAIL sat_reach: got %0d exp 15", lu_cnt); end
      repeat (5) tick();
      vec_cnt++;
      if (lu_cnt !== 4'd15) begin err_cnt++; $display("FAIL sat_hold: got %0d exp 15", lu_cnt); end
      cnt_clr = 1'b1;
      #1;
      vec_cnt++;
      if (ctl !== C_LU) begin err_cnt++; $display("FAIL clr_lu_ctl: got %b exp %b", ctl, C_LU); end
      tick();
      cnt_clr = 1'b0;
      idle();
      #1;
      vec_cnt++;
      if (lu_cnt !== 4'd0) begin err_cnt++; $display("FAIL clr_wins: got %0d exp 0", lu_cnt); end
   endtask

   task automatic test_timeout_one();
      pulse_reset();
      hz2.dmem_req = 1'b1;
      hz2.dmem_ready = 1'b0;
      #1;
      vec_cnt++;
      if ({mem_err2, ctl2} !== {1'b0, C_HOLD}) begin
         err_cnt++; $display("FAIL to1_first_cycle: got err=%b ctl=%b exp err=0 ctl=%b", mem_err2, ctl2, C_HOLD);
      end
      tick();
      hz2.dmem_ready = 1'b1;
      #1;
      vec_cnt++;
      if ({mem_err2, ctl2, mw_cnt2} !== {1'b1, C_HOLD, 16'd1}) begin
         err_cnt++; $display("FAIL to1_fault: got err=%b ctl=%b mw=%0d exp err=1 ctl=%b mw=1", mem_err2, ctl2, mw_cnt2, C_HOLD);
      end
      idle2();
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_branch_with_lu();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      test_freeze_with_branch();
      test_saturation();
      test_timeout_one();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule
